// File: rtl/sum_splitter_pkg.sv
// Shared constants and result type for the sum splitter block.
// Defaults match the registered byte adder feeding this block.
// The result struct packs the error flag above the recovered operand.
package sum_splitter_pkg;

   localparam int SS_DW_DEF    = 8;
   localparam int SS_DEPTH_DEF = 2;
   localparam int SS_ERRCNT_W  = 16;

   // One buffered result at the default operand width.
   typedef struct packed {
      logic                 err;
      logic [SS_DW_DEF-1:0] a;
   } ss_result_t;

endpackage : sum_splitter_pkg

// File: rtl/sum_splitter_fifo.sv
// Generic synchronous FIFO, W bits wide, DEPTH entries (any DEPTH >= 2).
// Latency: a push at edge N is visible on rdata_o after edge N; rdata_o is the head.
// Backpressure: none internally; the caller gates push on count < DEPTH and pop on count != 0.
//
// Ports: clk, rst (async active-high), push_i/wdata_i write side,
//        pop_i/rdata_o read side, count_o = number of stored entries.
module sum_splitter_fifo #(
   parameter  int W     = 9,
   parameter  int DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule : sum_splitter_fifo

// File: rtl/sum_splitter.sv
// Recovers operand a = sum - b from an adder's DW+1-bit sum, flagging out-of-range results.
// Latency: one cycle from accept to head of the output FIFO when it was empty.
// Backpressure: in_ready = count < DEPTH from registered count only; full FIFO holds off input.
//
// Ports: clk, rst (async active-high); in_valid/in_ready with sum_i, b_i;
//        out_valid/out_ready with a_o, range_err_o; err_cnt_o (saturating
//        range-error count) exists only when SUM_SPLITTER_ERR_CNT_EN is defined.
module sum_splitter
   import sum_splitter_pkg::*;
#(
   parameter int DW    = SS_DW_DEF,
   parameter int DEPTH = SS_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW:0]            sum_i,
   input  logic [DW-1:0]          b_i,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DW-1:0]          a_o,
`ifdef SUM_SPLITTER_ERR_CNT_EN
   output logic [SS_ERRCNT_W-1:0] err_cnt_o,
`endif
   output logic                   range_err_o
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic          err;
      logic [DW-1:0] a;
   } res_t;

   logic [DW:0]   diff;
   logic          borrow;
   logic          err;
   logic          accept;
   logic          pop;
   logic [CW-1:0] fifo_count;
   res_t          wres;
   res_t          rres;
   res_t          last_q, last_d;

   // Borrow means sum < b; diff[DW] set without borrow means a > 2^DW-1.
   assign diff   = sum_i - {1'b0, b_i};
   assign borrow = (sum_i < {1'b0, b_i});
   assign err    = borrow | diff[DW];

   assign wres.err = err;
   assign wres.a   = err ? '0 : diff[DW-1:0];

   assign in_ready  = ~rst & (fifo_count < CW'(DEPTH));
   assign out_valid = (fifo_count != '0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   sum_splitter_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i (wres),
      .rdata_o (rres),
      .count_o (fifo_count)
   );

   // Last popped result keeps the outputs steady while the FIFO is empty,
   // and gives the zero reset value of a_o/range_err_o.
   always_comb begin
      last_d = last_q;
      if (pop) begin
         last_d = rres;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= '0;
      end else begin
         last_q <= last_d;
      end
   end

   assign a_o         = out_valid ? rres.a   : last_q.a;
   assign range_err_o = out_valid ? rres.err : last_q.err;

`ifdef SUM_SPLITTER_ERR_CNT_EN
   logic [SS_ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + SS_ERRCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule : sum_splitter

// File: tb/tb_sum_splitter.sv
// Directed self-checking bench for sum_splitter (default DW=8, DEPTH=2).
// Inputs change and outputs are sampled on the falling clock edge.
// Error-counter scenarios build only when SUM_SPLITTER_ERR_CNT_EN is defined.
module tb_sum_splitter;
   import sum_splitter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] sum_i;
   logic [7:0] b_i;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] a_o;
   logic       range_err_o;
`ifdef SUM_SPLITTER_ERR_CNT_EN
   logic [15:0] err_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sum_splitter dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sum_i       (sum_i),
      .b_i         (b_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .a_o         (a_o),
`ifdef SUM_SPLITTER_ERR_CNT_EN
      .err_cnt_o   (err_cnt_o),
`endif
      .range_err_o (range_err_o)
   );

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_i = '0; b_i = '0;
      #1;
      repeat (2) cyc();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (a_o !== 8'd0) begin errors++; $display("FAIL reset_a_o got %0d want 0", a_o); end
      checks++; if (range_err_o !== 1'b0) begin errors++; $display("FAIL reset_range_err got %b want 0", range_err_o); end
      rst = 1'b0;
      cyc();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   // One transaction with out_ready high: result must appear the next cycle and leave the cycle after.
   task automatic do_single(input logic [8:0] s, input logic [7:0] b,
                            input logic [7:0] ea, input logic ee, input string nm);
      out_ready = 1'b1; in_valid = 1'b1; sum_i = s; b_i = b;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", nm, in_ready); end
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %b want 1", nm, out_valid); end
      checks++; if (a_o !== ea) begin errors++; $display("FAIL %s_a_o got %0d want %0d", nm, a_o, ea); end
      checks++; if (range_err_o !== ee) begin errors++; $display("FAIL %s_range_err got %b want %b", nm, range_err_o, ee); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got out_valid %b want 0", nm, out_valid); end
   endtask

   task automatic test_arith();
      do_single(9'd300, 8'd100, 8'd200, 1'b0, "basic");
      do_single(9'd5,   8'd10,  8'd0,   1'b1, "borrow");
      do_single(9'd510, 8'd0,   8'd0,   1'b1, "overflow");
      do_single(9'd510, 8'd255, 8'd255, 1'b0, "boundary");
      do_single(9'd256, 8'd0,   8'd0,   1'b1, "just_over");
      do_single(9'd255, 8'd0,   8'd255, 1'b0, "max_nob");
      // Empty FIFO holds the last popped result.
      checks++; if (a_o !== 8'd255) begin errors++; $display("FAIL empty_hold_a_o got %0d want 255", a_o); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; sum_i = 9'd10; b_i = 8'd3;   // a=7
      cyc();
      sum_i = 9'd20; b_i = 8'd5;                                      // a=15
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
      cyc();
      sum_i = 9'd30; b_i = 8'd1;                                      // a=29
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
      checks++; if (a_o !== 8'd7) begin errors++; $display("FAIL bp_head1 got %0d want 7", a_o); end
      cyc();
      checks++; if (a_o !== 8'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_stable got a_o=%0d vld=%b want 7/1", a_o, out_valid); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_no_comb_path got %b want 0", in_ready); end
      cyc();
      checks++; if (a_o !== 8'd15) begin errors++; $display("FAIL bp_order2 got %0d want 15", a_o); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got %b want 1", in_ready); end
      cyc();   // pop 2 and push 3 together
      in_valid = 1'b0;
      checks++; if (a_o !== 8'd29 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_order3 got a_o=%0d vld=%b want 29/1", a_o, out_valid); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [7:0] ea [20];
      logic [7:0] eb;
      int bad = 0;
      out_ready = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || a_o !== ea[i-1] || range_err_o !== 1'b0) begin
               errors++; bad++;
               $display("FAIL stream_%0d got vld=%b a=%0d err=%b want 1/%0d/0", i-1, out_valid, a_o, range_err_o, ea[i-1]);
            end
         end
         if (i < 20) begin
            ea[i] = 8'($urandom_range(0, 255));
            eb    = 8'($urandom_range(0, 255));
            sum_i = {1'b0, ea[i]} + {1'b0, eb};
            b_i   = eb;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         cyc();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_midstream_reset();
      out_ready = 1'b0; in_valid = 1'b1; sum_i = 9'd50; b_i = 8'd8;
      cyc();
      sum_i = 9'd60; b_i = 8'd9;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_async_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_async_ready got %b want 0", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", dut.fifo_count); end
      out_ready = 1'b1;
      repeat (3) begin
         cyc();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale got out_valid %b want 0", out_valid); end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
   endtask

`ifdef SUM_SPLITTER_ERR_CNT_EN
   task automatic test_err_cnt();
      checks++; if (err_cnt_o !== 16'd0) begin errors++; $display("FAIL errcnt_reset got %0d want 0", err_cnt_o); end
      do_single(9'd5,   8'd10,  8'd0,   1'b1, "ec_e1");
      do_single(9'd100, 8'd40,  8'd60,  1'b0, "ec_g1");
      do_single(9'd510, 8'd0,   8'd0,   1'b1, "ec_e2");
      do_single(9'd300, 8'd45,  8'd255, 1'b0, "ec_g2");
      do_single(9'd0,   8'd1,   8'd0,   1'b1, "ec_e3");
      checks++; if (err_cnt_o !== 16'd3) begin errors++; $display("FAIL errcnt_three got %0d want 3", err_cnt_o); end
      force dut.err_cnt_q = 16'hFFFE;
      #1;
      release dut.err_cnt_q;
      repeat (3) do_single(9'd1, 8'd2, 8'd0, 1'b1, "ec_sat");
      checks++; if (err_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL errcnt_saturate got %h want ffff", err_cnt_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_stream();
      test_midstream_reset();
`ifdef SUM_SPLITTER_ERR_CNT_EN
      test_err_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sum_splitter

// File: doc/sum_splitter.md
Name: sum_splitter

Overview:
- Receive-side counterpart of the registered byte adder (9-bit `sum` from two 8-bit operands).
- Takes a 9-bit sum plus the known 8-bit operand `b` and recovers the other operand `a = sum - b`.
- Flags results outside 0..2^DW-1.
- Valid/ready on both sides; a small output FIFO absorbs downstream back-pressure. Sits at the consumer end of the adder datapath.

Parameters:
- DW, 8, operand width; sum input is DW+1 bits.
- DEPTH, 2, output FIFO entries (>=2, any integer; pointers wrap explicitly at DEPTH-1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  sum_i/b_i valid.
- in_ready  output  1  block can accept an input this cycle.
- sum_i  input  DW+1  sum word from the adder.
- b_i  input  DW  known operand.
- out_valid  output  1  result at head of FIFO valid.
- out_ready  input  1  consumer takes result this cycle.
- a_o  output  DW  recovered operand.
- range_err_o  output  1  head result out of range.
- err_cnt_o  output  16  range-error count; present only with SUM_SPLITTER_ERR_CNT_EN.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - FIFO count and both pointers = 0.
  - out_valid = 0, a_o = 0, range_err_o = 0.
  - in_ready = 0, forced while rst is high.
- After rst deasserts, in_ready = 1 from the first clock edge onward.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (count < DEPTH). It is derived from registered count only and never combinationally from out_ready.
- Arithmetic, in DW+1 bits: diff = sum_i - {1'b0,b_i}.
  - err = borrow (sum_i < b_i) OR diff[DW] (result > 2^DW-1).
  - Stored a = err ? 0 : diff[DW-1:0]; the err bit is stored alongside.
- Latency: an input accepted at edge N is visible at edge N+1 (out_valid=1, a_o/range_err_o = its result) if the FIFO was empty. Results emerge strictly in order.
- Throughput is one result per cycle while out_ready is held high.
- Push and pop in the same cycle: count unchanged, both pointers advance. Legal at any count where in_ready=1.
- FIFO full (count=DEPTH): in_ready=0, inputs ignored, no overwrite. A pop that cycle makes in_ready=1 on the next cycle.
- FIFO empty: out_valid=0, a_o/range_err_o hold their last values (don't-care to the consumer). A pop while empty is impossible by definition.
- a_o/range_err_o are stable while out_valid & !out_ready.
- Pointers wrap from DEPTH-1 to 0.
- Reset asserted mid-stream: all buffered results are discarded, no partial output.

Optional Feature:
- Macro: SUM_SPLITTER_ERR_CNT_EN.
- When defined:
  - err_cnt_o port exists.
  - 16-bit counter increments on each accepted input whose err=1, saturating at 16'hFFFF.
  - Reset to 0.
- When undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Package sum_splitter_pkg:
  - SS_DW_DEF=8, SS_DEPTH_DEF=2, SS_ERRCNT_W=16.
  - Packed struct ss_result_t {logic err; logic [DW-1:0] a;} for the default width.
- Sub-module sum_splitter_fifo:
  - Generic synchronous FIFO with parameters W and DEPTH.
  - Ports: push, pop, wdata, rdata, count; async active-high rst.
  - Instantiated once with W=DW+1.
- Subtraction and error logic stay in the top.

Test Plan:
- Reset release, then sum_i=9'd300, b_i=8'd100, out_ready=1 -> next cycle out_valid=1, a_o=200, range_err_o=0; in_ready=1 throughout.
- Borrow: sum_i=9'd5, b_i=8'd10 -> a_o=0, range_err_o=1. Overflow: sum_i=9'd510, b_i=8'd0 -> a_o=0, range_err_o=1. Boundary: sum_i=9'd510, b_i=8'd255 -> a_o=255, range_err_o=0.
- Back-pressure: out_ready=0, push 3 inputs with in_valid held high.
  - in_ready drops after the 2nd accept; the 3rd is held off.
  - Head stays the first result.
  - Raise out_ready -> results appear in order 1,2,3 with no loss.
- Streaming: in_valid=out_ready=1 for 20 cycles with random legal pairs (sum_i=a+b) -> 20 results, a_o matches each a, one per cycle, no bubbles after the first.
- Reset mid-stream: FIFO holding 2 results, assert rst for 1 cycle -> out_valid=0 immediately (async); after release, count=0 and no stale results emerge.
- With SUM_SPLITTER_ERR_CNT_EN defined: 3 erroring inputs plus 2 good ones -> err_cnt_o=3. Preload or force the counter to 16'hFFFE, then 3 errors -> stays at 16'hFFFF.
